// File: rtl/kpn_fxp_addsub_pipe.sv
// Decimal-fraction fixed-point add/subtract actor: one compute stage feeding a FWFT output FIFO.
// Optional build macro KPN_ADDSUB_SAT_EN saturates overflowed results instead of wrapping.
module kpn_fxp_addsub_pipe #(
    parameter int INT_W     = 12,
    parameter int FRAC_W    = 4,
    parameter int FRAC_BASE = 10,
    parameter int DEPTH     = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [INT_W+FRAC_W-1:0]    in_a_data,
    input  logic                       in_a_valid,
    output logic                       in_a_rd,
    input  logic [INT_W+FRAC_W-1:0]    in_b_data,
    input  logic                       in_b_valid,
    output logic                       in_b_rd,
    input  logic                       op,
    output logic [INT_W+FRAC_W-1:0]    out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_ovf,
    output logic                       out_err,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count
);
    localparam int W  = INT_W + FRAC_W;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [FRAC_W+1:0] FB = (FRAC_W + 2)'(FRAC_BASE);

    logic [FRAC_W-1:0] fa, fb;
    logic [FRAC_W+1:0] fsum, fadj;
    logic [INT_W+1:0]  ia, ib, isum;
    logic              cy, ill, ovf_c;
    logic [W-1:0]      res_c;

    logic              s1_valid, s1_ovf, s1_err;
    logic [W-1:0]      s1_data;

    logic [W+1:0]      mem [DEPTH];
    logic [PW-1:0]     rd_ptr, wr_ptr;
    logic [CW-1:0]     count;
    logic [CW:0]       occ;
    logic              push, pop, fire;
    logic [W+1:0]      head;

    always_comb begin
        fa   = in_a_data[FRAC_W-1:0];
        fb   = in_b_data[FRAC_W-1:0];
        ia   = {{2{in_a_data[W-1]}}, in_a_data[W-1:FRAC_W]};
        ib   = {{2{in_b_data[W-1]}}, in_b_data[W-1:FRAC_W]};
        ill  = ({2'b00, fa} >= FB) || ({2'b00, fb} >= FB);
        if (op) begin
            fsum = {2'b00, fa} + {2'b00, fb};
            cy   = (fsum >= FB);
            fadj = cy ? fsum - FB : fsum;
            isum = ia + ib + {{(INT_W + 1){1'b0}}, cy};
        end else begin
            fsum = {2'b00, fa} - {2'b00, fb};
            cy   = fsum[FRAC_W+1];
            fadj = cy ? fsum + FB : fsum;
            isum = ia - ib - {{(INT_W + 1){1'b0}}, cy};
        end
        // Result fits when the two guard bits match the INT_W sign bit.
        ovf_c = !((isum[INT_W+1:INT_W-1] == 3'b000) ||
                  (isum[INT_W+1:INT_W-1] == 3'b111));
        res_c = {isum[INT_W-1:0], fadj[FRAC_W-1:0]};
`ifdef KPN_ADDSUB_SAT_EN
        if (ovf_c) begin
            res_c = isum[INT_W+1]
                  ? {1'b1, {(INT_W - 1){1'b0}}, {FRAC_W{1'b0}}}
                  : {1'b0, {(INT_W - 1){1'b1}}, FRAC_W'(FRAC_BASE - 1)};
        end
`endif
        if (ill) begin
            res_c = '0;
            ovf_c = 1'b0;
        end
    end

    // occ counts every token in flight; s1 always drains into the FIFO next cycle.
    assign occ     = {1'b0, count} + {{CW{1'b0}}, s1_valid};
    assign out_valid = (count != '0);
    assign pop     = out_valid & out_ready;
    assign push    = s1_valid;
    assign fire    = !reset & in_a_valid & in_b_valid &
                     ((occ < (CW + 1)'(DEPTH)) | pop);
    assign in_a_rd = fire;
    assign in_b_rd = fire;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_ovf   <= 1'b0;
            s1_err   <= 1'b0;
        end else begin
            s1_valid <= fire;
            if (fire) begin
                s1_data <= res_c;
                s1_ovf  <= ovf_c;
                s1_err  <= ill;
            end
        end
    end

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {s1_err, s1_ovf, s1_data};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= nxt(wr_ptr);
            if (pop)  rd_ptr <= nxt(rd_ptr);
            unique case (1'b1)
                (push && !pop): count <= count + 1'b1;
                (pop && !push): count <= count - 1'b1;
                default:        count <= count;
            endcase
        end
    end

    assign head       = mem[rd_ptr];
    assign out_data   = out_valid ? head[W-1:0] : '0;
    assign out_ovf    = out_valid & head[W];
    assign out_err    = out_valid & head[W+1];
    assign fifo_count = count;
endmodule
